ensemble_scheduler: RTL and testbench
=====================================

ENSEMBLE_SCHEDULER -- requirements
Module: ensemble_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, stream data width | KEEP_WIDTH, 4, byte-keep width | LABEL_W, 8, class-label width (1..8) | TIMEOUT, 1024, max COLLECT cycles (>=2).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 s_axis_tdata/tkeep/tvalid/tlast  in  DATA_WIDTH/KEEP_WIDTH/1/1  upstream feature frame; s_axis_tready  out  1.
REQ-005 c_axis_tdata/tkeep/tlast  out  DATA_WIDTH/KEEP_WIDTH/1  feature beat broadcast to classifiers 0,1,2; c_axis_tvalid  out  3, per classifier; c_axis_tready  in  3.
REQ-006 r_axis_tdata  in  3*DATA_WIDTH  classifier i result at [i*DATA_WIDTH +: DATA_WIDTH]; r_axis_tvalid  in  3; r_axis_tready  out  3.
REQ-007 m_axis_tdata/tkeep/tvalid/tlast  out  DATA_WIDTH/KEEP_WIDTH/1/1  voted result; m_axis_tready  in  1.
REQ-008 frame_count, timeout_count  out  16 each  emitted frames, timed-out frames; busy  out  1  state != SEND or partial frame in flight.

Function
REQ-009 FSM states SHALL be SEND, COLLECT, EMIT; reset state SEND.
REQ-010 SEND: c_axis_tdata/tkeep/tlast = s_axis_*; c_axis_tvalid[i] = s_axis_tvalid & ~sent[i].
REQ-011 sent[i] SHALL set on c_axis_tvalid[i] & c_axis_tready[i] when beat not yet accepted upstream; all sent[] clear when the upstream beat is accepted.
REQ-012 s_axis_tready SHALL be high only in SEND and only when, for every i, sent[i] | c_axis_tready[i]; each beat reaches each classifier exactly once, branches may accept on different cycles.
REQ-013 Upstream accept of beat with s_axis_tlast=1 SHALL move SEND->COLLECT next cycle; got[] and timeout counter clear on entry.
REQ-014 COLLECT: r_axis_tready[i] = ~got[i]; on handshake capture r_axis_tdata[i][LABEL_W-1:0] into label[i], set got[i]; only one result beat per classifier per frame.
REQ-015 COLLECT->EMIT when got==3'b111 (cycle after last capture) or when counter reaches TIMEOUT-1 with got!=3'b111 (timeout flag set); counter increments every COLLECT cycle.
REQ-016 Simultaneous final capture and TIMEOUT-1: capture wins, no timeout flag.
REQ-017 SEND and EMIT: r_axis_tready = 3'b111 and incoming result beats discarded (stale/late drain).
REQ-018 Vote among valid labels (got[i]=1), computed registered on EMIT entry: any label held by >=2 valid classifiers wins; otherwise highest-index valid classifier wins (2 over 1 over 0); no valid classifier -> label 0.
REQ-019 m_axis_tdata SHALL be: [LABEL_W-1:0] label, [8] unanimous (got=111 and all three equal), [9] timeout, [12:10] got mask, other bits 0; tkeep all ones; tlast 1.
REQ-020 EMIT: m_axis_tvalid=1, tdata stable until m_axis_tready; on handshake -> SEND, frame_count+1, timeout_count+1 if timeout flag; counters wrap at 16'hFFFF->0.
REQ-021 Throughput: minimum frame cost = beats + 1 (COLLECT) + 1 (EMIT) cycles with all readies high and results returned in one cycle.

Reset
REQ-022 rst SHALL, on the next edge, force SEND, clear sent[], got[], labels, flags, counters, frame_count, timeout_count; all tvalid outputs 0, s_axis_tready follows REQ-012 with sent[] cleared, busy 0.
REQ-023 Reset mid-frame SHALL drop the partial frame with no output beat; the following frame is processed normally.

Verification
REQ-024 3-beat frame, all readies 1, results 5,5,7 next cycle -> one output beat tdata=0x1C05 (label 5, mask 111, not unanimous), frame_count=1.
REQ-025 c_axis_tready toggled per classifier at random -> each classifier receives each of 3 beats exactly once in order; s_axis_tready low until all branches taken.
REQ-026 Results 3,4,9 -> label 9 (classifier 2), tdata=0x1C09; results 6,6,6 -> tdata=0x1D06.
REQ-027 Classifier 1 never responds, 0=2, 2=4, TIMEOUT=16 -> EMIT after 16 COLLECT cycles, tdata=0x1604, timeout_count=1; late beat from classifier 1 drained in SEND.
REQ-028 m_axis_tready held 0 for 10 cycles in EMIT -> tdata stable, no new s_axis accept; rst asserted mid-frame -> no output, counters 0, next frame correct.

Source files
------------

// File: rtl/ensemble_scheduler.sv
// ensemble_scheduler
// Broadcasts each upstream feature frame to three classifiers, collects one
// class label from each, majority-votes them and emits a single result beat.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 upstream feature frame (AXI-Stream slave)
//   c_axis_*                 feature beat broadcast, per-classifier tvalid/tready
//   r_axis_*                 classifier results, classifier i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*                 voted result beat (AXI-Stream master)
//   frame_count              number of emitted frames (wraps)
//   timeout_count            number of emitted frames that timed out (wraps)
//   busy                     a frame is in progress
//
// Result word: [LABEL_W-1:0] label, [8] unanimous, [9] timeout, [12:10] got mask.
module ensemble_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int LABEL_W    = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   c_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   c_axis_tkeep,
    output logic                    c_axis_tlast,
    output logic [2:0]              c_axis_tvalid,
    input  logic [2:0]              c_axis_tready,
    input  logic [3*DATA_WIDTH-1:0] r_axis_tdata,
    input  logic [2:0]              r_axis_tvalid,
    output logic [2:0]              r_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [15:0]             frame_count,
    output logic [15:0]             timeout_count,
    output logic                    busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SEND    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    state_t                     state_r;
    logic [2:0]                 sent_r;
    logic [2:0]                 got_r;
    logic [2:0][LABEL_W-1:0]    label_r;
    logic [CNT_W-1:0]           tmo_cnt_r;
    logic                       tmo_flag_r;
    logic                       in_frame_r;
    logic                       m_valid_r;
    logic [DATA_WIDTH-1:0]      m_data_r;
    logic [15:0]                frame_cnt_r;
    logic [15:0]                tmo_frames_r;

    logic                       s_ready_s;
    logic                       s_accept_s;
    logic [2:0]                 c_valid_s;
    logic [2:0]                 r_ready_s;
    logic [2:0]                 r_hs_s;
    logic [2:0]                 got_next_s;
    logic [2:0][LABEL_W-1:0]    label_next_s;
    logic                       all_got_s;
    logic                       tmo_hit_s;
    logic [DATA_WIDTH-1:0]      vote_word_s;
    logic                       unused_r_bits_s;

    // Majority among valid labels; otherwise highest-index valid classifier.
    function automatic logic [LABEL_W-1:0] vote_label(
        input logic [2:0][LABEL_W-1:0] lbl,
        input logic [2:0]              g
    );
        logic [LABEL_W-1:0] res;
        if (g[0] && g[1] && (lbl[0] == lbl[1])) begin
            res = lbl[0];
        end else if (g[0] && g[2] && (lbl[0] == lbl[2])) begin
            res = lbl[0];
        end else if (g[1] && g[2] && (lbl[1] == lbl[2])) begin
            res = lbl[1];
        end else if (g[2]) begin
            res = lbl[2];
        end else if (g[1]) begin
            res = lbl[1];
        end else if (g[0]) begin
            res = lbl[0];
        end else begin
            res = {LABEL_W{1'b0}};
        end
        return res;
    endfunction

    // Packs label, unanimity, timeout and got mask into the result word.
    function automatic logic [DATA_WIDTH-1:0] pack_result(
        input logic [2:0][LABEL_W-1:0] lbl,
        input logic [2:0]              g,
        input logic                    tmo
    );
        logic [DATA_WIDTH-1:0] w;
        w              = {DATA_WIDTH{1'b0}};
        w[LABEL_W-1:0] = vote_label(lbl, g);
        w[8]           = (g == 3'b111) && (lbl[0] == lbl[1]) && (lbl[1] == lbl[2]);
        w[9]           = tmo;
        w[12:10]       = g;
        return w;
    endfunction

    // Broadcast path and upstream ready: a beat is released upstream only
    // once every classifier has either taken it or is taking it now.
    always_comb begin
        c_valid_s = 3'b000;
        s_ready_s = 1'b0;
        if (state_r == ST_SEND) begin
            c_valid_s = {3{s_axis_tvalid}} & ~sent_r;
            s_ready_s = &(sent_r | c_axis_tready);
        end else begin
            c_valid_s = 3'b000;
            s_ready_s = 1'b0;
        end
    end

    // Result-side ready: accept one beat per classifier in COLLECT, drain otherwise.
    always_comb begin
        r_ready_s = 3'b111;
        r_hs_s    = 3'b000;
        if (state_r == ST_COLLECT) begin
            r_ready_s = ~got_r;
            r_hs_s    = r_axis_tvalid & ~got_r;
        end else begin
            r_ready_s = 3'b111;
            r_hs_s    = 3'b000;
        end
    end

    // Next-cycle view of captured labels so the vote can be registered on EMIT entry.
    always_comb begin
        label_next_s = label_r;
        for (int i = 0; i < 3; i++) begin
            if (r_hs_s[i]) begin
                label_next_s[i] = r_axis_tdata[i*DATA_WIDTH +: LABEL_W];
            end else begin
                label_next_s[i] = label_r[i];
            end
        end
        got_next_s  = got_r | r_hs_s;
        all_got_s   = &got_next_s;
        // A capture completing the set on the last cycle beats the timeout.
        tmo_hit_s   = (tmo_cnt_r == TMO_LAST) && !all_got_s;
        vote_word_s = pack_result(label_next_s, got_next_s, tmo_hit_s);
    end

    assign s_accept_s      = s_axis_tvalid & s_ready_s;
    assign unused_r_bits_s = ^r_axis_tdata;

    // Scheduler FSM, counters and registered result beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SEND;
            sent_r       <= 3'b000;
            got_r        <= 3'b000;
            label_r      <= '0;
            tmo_cnt_r    <= {CNT_W{1'b0}};
            tmo_flag_r   <= 1'b0;
            in_frame_r   <= 1'b0;
            m_valid_r    <= 1'b0;
            m_data_r     <= {DATA_WIDTH{1'b0}};
            frame_cnt_r  <= 16'd0;
            tmo_frames_r <= 16'd0;
        end else begin
            case (state_r)
                ST_SEND: begin
                    if (s_accept_s) begin
                        sent_r <= 3'b000;
                        if (s_axis_tlast) begin
                            state_r    <= ST_COLLECT;
                            got_r      <= 3'b000;
                            tmo_cnt_r  <= {CNT_W{1'b0}};
                            in_frame_r <= 1'b0;
                        end else begin
                            in_frame_r <= 1'b1;
                        end
                    end else begin
                        sent_r <= sent_r | (c_valid_s & c_axis_tready);
                    end
                end
                ST_COLLECT: begin
                    got_r     <= got_next_s;
                    label_r   <= label_next_s;
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    if (all_got_s || tmo_hit_s) begin
                        state_r    <= ST_EMIT;
                        m_valid_r  <= 1'b1;
                        m_data_r   <= vote_word_s;
                        tmo_flag_r <= tmo_hit_s;
                    end
                end
                ST_EMIT: begin
                    if (m_axis_tready) begin
                        state_r     <= ST_SEND;
                        m_valid_r   <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        if (tmo_flag_r) begin
                            tmo_frames_r <= tmo_frames_r + 16'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_SEND;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_s;
    assign c_axis_tdata  = s_axis_tdata;
    assign c_axis_tkeep  = s_axis_tkeep;
    assign c_axis_tlast  = s_axis_tlast;
    assign c_axis_tvalid = c_valid_s;
    assign r_axis_tready = r_ready_s;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = 1'b1;
    assign frame_count   = frame_cnt_r;
    assign timeout_count = tmo_frames_r;
    assign busy          = (state_r != ST_SEND) || in_frame_r || (|sent_r);

endmodule

// File: tb/tb_ensemble_scheduler.sv
// Self-checking bench for ensemble_scheduler (TIMEOUT overridden to 16).
module tb_ensemble_scheduler;

    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int LW  = 8;
    localparam int TMO = 16;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   c_axis_tdata;
    logic [KW-1:0]   c_axis_tkeep;
    logic            c_axis_tlast;
    logic [2:0]      c_axis_tvalid;
    logic [2:0]      c_axis_tready;
    logic [3*DW-1:0] r_axis_tdata;
    logic [2:0]      r_axis_tvalid;
    logic [2:0]      r_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [15:0]     frame_count;
    logic [15:0]     timeout_count;
    logic            busy;

    ensemble_scheduler #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .LABEL_W    (LW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .c_axis_tdata  (c_axis_tdata),
        .c_axis_tkeep  (c_axis_tkeep),
        .c_axis_tlast  (c_axis_tlast),
        .c_axis_tvalid (c_axis_tvalid),
        .c_axis_tready (c_axis_tready),
        .r_axis_tdata  (r_axis_tdata),
        .r_axis_tvalid (r_axis_tvalid),
        .r_axis_tready (r_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_count   (frame_count),
        .timeout_count (timeout_count),
        .busy          (busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            recv_cnt[3];
    int            s_beat = 0;
    int            cur_nbeats = 0;
    logic [DW-1:0] cur_base = '0;
    int            cyc = 0;
    int            t_last = 0;
    int            t_mv = 0;
    logic          mv_prev = 1'b0;
    int            out_cnt = 0;
    int            exp_fc = 0;
    int            exp_tc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: classifier beat order, upstream release rule, output scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (c_axis_tvalid[i] && c_axis_tready[i]) begin
                    check_val($sformatf("c%0d_beat_data", i), c_axis_tdata, cur_base + DW'(recv_cnt[i]));
                    check_val($sformatf("c%0d_beat_last", i), DW'(c_axis_tlast), DW'(recv_cnt[i] == cur_nbeats - 1));
                    recv_cnt[i]++;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                for (int i = 0; i < 3; i++) begin
                    check_val($sformatf("s_accept_after_c%0d", i), DW'(recv_cnt[i]), DW'(s_beat + 1));
                end
                s_beat++;
                if (s_axis_tlast) t_last = cyc;
            end
            if (m_axis_tvalid && !mv_prev) t_mv = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                check_val("output_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    check_val("m_tdata", m_axis_tdata, exp_q.pop_front());
                    check_val("m_tkeep_tlast", DW'({m_axis_tkeep, m_axis_tlast}), DW'(5'h1F));
                end
                out_cnt++;
            end
            mv_prev = m_axis_tvalid;
        end else begin
            mv_prev = 1'b0;
        end
        cyc++;
    end

    task automatic run_frame(input int nb, input logic [DW-1:0] base,
                             input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic [LW-1:0] l2,
                             input logic [2:0] resp, input bit rnd, input int hold,
                             input logic [DW-1:0] exp_word, input bit exp_tmo, input int exp_lat);
        int            beat = 0;
        int            guard = 0;
        int            outs0;
        logic [2:0]    pend;
        logic [DW-1:0] held;
        outs0      = out_cnt;
        cur_base   = base;
        cur_nbeats = nb;
        for (int i = 0; i < 3; i++) recv_cnt[i] = 0;
        s_beat = 0;
        exp_q.push_back(exp_word);
        m_axis_tready = (hold == 0);
        while (beat < nb && guard < 200) begin
            c_axis_tready = rnd ? 3'($urandom_range(0, 7)) : 3'b111;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(beat);
            s_axis_tlast  = (beat == nb - 1);
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) beat++;
            @(posedge clk); #1;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        c_axis_tready = 3'b111;
        check_val("beats_accepted", DW'(beat), DW'(nb));
        for (int i = 0; i < 3; i++) check_val($sformatf("c%0d_beats_total", i), DW'(recv_cnt[i]), DW'(nb));
        // classifier results, each held until accepted
        r_axis_tdata = {DW'(l2), DW'(l1), DW'(l0)};
        pend  = resp;
        guard = 0;
        while (pend != 3'b000 && guard < 50) begin
            r_axis_tvalid = pend;
            @(negedge clk);
            pend = pend & ~(r_axis_tvalid & r_axis_tready);
            @(posedge clk); #1;
            guard++;
        end
        r_axis_tvalid = 3'b000;
        check_val("results_accepted", DW'(pend), DW'(0));
        guard = 0;
        @(negedge clk);
        while (!m_axis_tvalid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("m_valid_seen", DW'(m_axis_tvalid), DW'(1));
        if (hold > 0) begin
            held          = m_axis_tdata;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEAD_BEEF;
            repeat (hold) begin
                @(negedge clk);
                check_val("hold_tdata_stable", m_axis_tdata, held);
                check_val("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
                check_val("hold_no_s_accept", DW'(s_axis_tready), DW'(0));
                check_val("hold_r_drain", DW'(r_axis_tready), DW'(3'b111));
            end
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
        end
        guard = 0;
        while (out_cnt == outs0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        exp_fc++;
        if (exp_tmo) exp_tc++;
        check_val("output_count", DW'(out_cnt - outs0), DW'(1));
        check_val("frame_count", DW'(frame_count), DW'(exp_fc));
        check_val("timeout_count", DW'(timeout_count), DW'(exp_tc));
        check_val("latency", DW'(t_mv - t_last), DW'(exp_lat));
        check_val("idle_after_frame", DW'({busy, m_axis_tvalid}), DW'(0));
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 4'hF;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        c_axis_tready = 3'b111;
        r_axis_tdata  = '0;
        r_axis_tvalid = 3'b000;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) recv_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_m_valid", DW'(m_axis_tvalid), DW'(0));
        check_val("rst_counts", DW'({frame_count, timeout_count}), DW'(0));
        check_val("rst_busy", DW'(busy), DW'(0));
        check_val("rst_s_ready", DW'(s_axis_tready), DW'(1));
        check_val("rst_c_valid", DW'(c_axis_tvalid), DW'(0));
        check_val("rst_r_ready", DW'(r_axis_tready), DW'(3'b111));
        @(posedge clk); #1;

        // 5,5,7 -> majority 5, not unanimous
        run_frame(3, 32'h0000_0100, 8'd5, 8'd5, 8'd7, 3'b111, 1'b0, 0, 32'h0000_1C05, 1'b0, 2);
        // random per-classifier readiness; 3,4,9 -> no majority, classifier 2 wins
        run_frame(3, 32'h0000_0200, 8'd3, 8'd4, 8'd9, 3'b111, 1'b1, 0, 32'h0000_1C09, 1'b0, 2);
        // unanimous 6
        run_frame(3, 32'h0000_0300, 8'd6, 8'd6, 8'd6, 3'b111, 1'b0, 0, 32'h0000_1D06, 1'b0, 2);
        // classifier 1 silent -> timeout after 16 COLLECT cycles, label 4 from classifier 2
        run_frame(2, 32'h0000_0400, 8'd2, 8'd0, 8'd4, 3'b101, 1'b0, 0, 32'h0000_1604, 1'b1, TMO + 1);
        // late result from classifier 1 drained in SEND
        r_axis_tvalid = 3'b010;
        r_axis_tdata  = {DW'(0), DW'(8'hEE), DW'(0)};
        @(negedge clk);
        check_val("late_drain_ready", DW'(r_axis_tready), DW'(3'b111));
        @(posedge clk); #1;
        r_axis_tvalid = 3'b000;
        // back-pressure on output for 10 cycles; 1,2,1 -> classifiers 0 and 2 agree
        run_frame(1, 32'h0000_0500, 8'd1, 8'd2, 8'd1, 3'b111, 1'b1, 10, 32'h0000_1C01, 1'b0, 2);

        // reset in the middle of a frame
        cur_base   = 32'h0000_0600;
        cur_nbeats = 3;
        for (int i = 0; i < 3; i++) recv_cnt[i] = 0;
        s_beat = 0;
        for (int b = 0; b < 2; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h0000_0600 + DW'(b);
            s_axis_tlast  = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check_val("busy_mid_frame", DW'(busy), DW'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_fc = 0;
        exp_tc = 0;
        @(negedge clk);
        check_val("mid_rst_counts", DW'({frame_count, timeout_count}), DW'(0));
        check_val("mid_rst_busy", DW'(busy), DW'(0));
        check_val("mid_rst_s_ready", DW'(s_axis_tready), DW'(1));
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_rst_no_output", DW'(out_cnt), DW'(5));
        run_frame(3, 32'h0000_0700, 8'd8, 8'd9, 8'd8, 3'b111, 1'b0, 0, 32'h0000_1C08, 1'b0, 2);

        check_val("scoreboard_empty", DW'(exp_q.size()), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
